qc_bus_responder: RTL
=====================

# qc_bus_responder

Pin-level memory target for the `tt_um_quick_cpu` external bus, on the far side of the CPU's `uo_out`/`uio` pins. It is used on the bench and in the FPGA harness as the memory the CPU talks to. It accepts read and write requests over an 8-bit multiplexed address/data bus, applies a programmable number of wait states, and answers with a one-cycle `ack`, returning read data when required. Storage is a small register-based memory of `DEPTH` bytes.

## Interface
- `DEPTH`, 16: bytes of storage. Power of two, 2..256. `AW = log2(DEPTH)`.
- `WAIT_CYCLES`, 2: extra wait cycles per access, 0..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `req`  in  1  request from CPU; held high until `ack` is seen.
- `we`  in  1  1 = write, 0 = read; sampled only on the request-accept edge.
- `addr_data`  in  8  address on accept edge; write data on the following edge (writes only).
- `rdata`  out  8  read data, valid while `rdata_oe` = 1.
- `rdata_oe`  out  1  drive enable for `rdata` (maps to `uio_oe` on the pins).
- `ack`  out  1  one-cycle transfer-complete strobe.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, WDATA, WAIT, ACK, HOLD. All outputs are registered.
- **Reset (async):**
  - State is IDLE.
  - `ack`, `rdata_oe`, `busy` are 0.
  - `rdata` is 0x00.
  - Every memory byte is 0x00.
  - Wait counter is 0.
- **IDLE:**
  - On an edge with `req` = 1, latch `addr_data[AW-1:0]` as the address and latch `we`. This is the accept edge E0.
  - Bits `[7:AW]` of the address are ignored, so addresses wrap modulo `DEPTH`.
  - Go to WDATA if `we` = 1. Otherwise go to WAIT with the counter set to `WAIT_CYCLES`.
- **WDATA:**
  - On the next edge, latch `addr_data` as the write data.
  - Go to WAIT with the counter set to `WAIT_CYCLES`.
- **WAIT:**
  - Each edge with counter ≠ 0 decrements the counter.
  - The edge with counter = 0 goes to ACK.
  - WAIT therefore lasts exactly `WAIT_CYCLES+1` cycles.
- **Edge entering ACK:**
  - Write: `mem[addr] <= wdata` (commit point).
  - Read: `rdata <= mem[addr]`.
- **ACK:** lasts one cycle.
  - `ack` = 1.
  - `rdata_oe` = 1 for reads only.
  - On exit, go to IDLE if `req` = 0, otherwise to HOLD.
- **HOLD:**
  - Stay while `req` = 1. Go to IDLE on the first edge with `req` = 0.
  - A new request is accepted only from IDLE, so `req` must be seen low for at least one edge between transfers.
- **Abort:**
  - `req` = 0 on any edge in WDATA or WAIT returns the block to IDLE.
  - No `ack` is produced and memory is unchanged.
- **`rdata` hold:** `rdata` keeps its last value when `rdata_oe` = 0. Only `rdata_oe` gates the pins.
- **`busy`:** registered copy of (next state ≠ IDLE).

## Timing
- Read: `ack` and `rdata_oe` are high in the cycle after edge E0+`WAIT_CYCLES`+1.
  - With the default of 2, `ack` is high between E3 and E4.
- Write: `ack` is high in the cycle after edge E0+`WAIT_CYCLES`+2.
  - With the default of 2, `ack` is high between E4 and E5.
  - Memory is updated at E4.
- Minimum request spacing:
  - Read: `WAIT_CYCLES`+3 cycles (accept, WAIT, ACK, one IDLE cycle with `req` low).
  - Write: `WAIT_CYCLES`+4 cycles.
- A read of an address returns the data committed by any write whose ACK-entry edge came earlier.
- Reset asserted mid-transfer:
  - Returns to IDLE immediately and clears `ack`/`rdata_oe` combinationally through the async reset.
  - Clears memory. An uncommitted write is lost.
- `we` or `addr_data` changing after it has been sampled has no effect.

## Test plan
- **Reset:** hold `rst_n` = 0 mid-WAIT of a read.
  - Outputs go to 0 at once.
  - After release, a read of address 0x05 returns 0x00.
- **Write/read, `WAIT_CYCLES` = 2:** write 0xA5 to 0x03, then read 0x03.
  - Write `ack` comes 5 cycles after accept.
  - Read `ack` and `rdata_oe` come 4 cycles after accept, with `rdata` = 0xA5.
  - `ack` is high for exactly 1 cycle each time.
- **Wrap-around, `DEPTH` = 16:** write 0x3C to address 0x13, then read 0x03.
  - Read returns 0x3C.
- **Abort:** start a write of 0x77 to 0x07 and drop `req` in WAIT.
  - No `ack`, `busy` falls.
  - A following read of 0x07 returns the previous value 0x00.
- **HOLD:** keep `req` high for 3 cycles after `ack`, then drop it, then raise it immediately.
  - `busy` stays high through HOLD.
  - The second request is accepted only on the edge after the IDLE cycle.
  - Exactly one `ack` per transfer.
- **`WAIT_CYCLES` = 0:** back-to-back reads of 0x00 and 0x01 with `req` low for one edge between them.
  - Each `ack` comes 2 cycles after its accept.
  - `rdata` values are correct.

Source files
------------

// File: rtl/qc_bus_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qc_bus_responder
//
// Pin-level memory target for the quick_cpu external bus. The CPU presents an
// address on the multiplexed 8-bit bus when it raises req, then (for writes)
// the data byte on the following edge. After a fixed number of wait states the
// responder pulses ack for one cycle, returning read data with rdata_oe high.
// Storage is a small register array that is cleared by reset.
//
// Parameters
//   DEPTH        bytes of storage, power of two, 2..256
//   WAIT_CYCLES  extra wait cycles per access, 0..15
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request from CPU, held high until ack is seen
//   we         1 = write, 0 = read, sampled on the accept edge
//   addr_data  address on the accept edge, write data on the next edge
//   rdata      read data, valid while rdata_oe is high, holds otherwise
//   rdata_oe   drive enable for rdata (uio_oe on the pins)
//   ack        one-cycle transfer-complete strobe
//   busy       high whenever the responder is not idle
// -----------------------------------------------------------------------------
module qc_bus_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr_data,
  output logic [7:0] rdata,
  output logic       rdata_oe,
  output logic       ack,
  output logic       busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            mem_wr;

  logic [7:0]      mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_wr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Upper address bits are dropped, so addresses wrap modulo DEPTH.
          addr_d  = addr_data[AW-1:0];
          we_d    = we;
          cnt_d   = WAIT_INIT;
          state_d = we ? S_WDATA : S_WAIT;
        end
      end

      S_WDATA: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          wdata_d = addr_data;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!req) begin
          // Abort: nothing has been committed yet, so just drop the transfer.
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The edge entering ACK is the single commit point for both
          // directions, so an aborted transfer never touches memory/rdata.
          state_d = S_ACK;
          if (we_q) begin
            mem_wr = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
        end
      end

      S_ACK: begin
        state_d = req ? S_HOLD : S_IDLE;
      end

      S_HOLD: begin
        // A new request is only taken from IDLE, so req must be seen low once.
        if (!req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    ack_d  = (state_d == S_ACK);
    oe_d   = (state_d == S_ACK) && !we_q;
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: register array, cleared by reset (an uncommitted write is lost).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_wr) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rdata    = rdata_q;
  assign rdata_oe = oe_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule
